exec_sequencer: RTL and testbench
=================================

# exec_sequencer

Instruction execution sequencer that sits directly downstream of the instruction fetcher. It detects each new instruction handed over by the fetcher and latches the opcode, effective address and immediate. It then runs the data-bus cycles the instruction needs (operand read, store, or read-modify-write), presents the operand to the ALU, and pulses `instruction_done` to start the next fetch.

## Interface
- `REG_WIDTH`, default 8: data/register width.
- `ADDR_WIDTH`, default 16: address width.

Ports:
- `phi1`  in  1  sole clock; all state updates on posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `instruction_ready`  in  1  fetcher's level-high "opcode/addr/imm valid".
- `instruction_in`  in  REG_WIDTH  opcode.
- `addr_in`  in  ADDR_WIDTH  effective address.
- `imm_in`  in  REG_WIDTH  immediate byte.
- `reg_a`, `reg_x`, `reg_y`  in  REG_WIDTH  register-file values used as store sources.
- `alu_result`  in  REG_WIDTH  combinational ALU output computed from `operand`.
- `mem_rdata`  in  REG_WIDTH  memory read data, valid in the same cycle as `mem_rd`.
- `mem_addr`  out  ADDR_WIDTH  bus address.
- `mem_rd`, `mem_wr`  out  1  bus strobes; never both high.
- `mem_wdata`  out  REG_WIDTH  write data.
- `operand`  out  REG_WIDTH  operand for the ALU.
- `operand_valid`  out  1  one-cycle qualifier for `operand`.
- `busy`  out  1  high in any state other than IDLE.
- `instruction_done`  out  1  one-cycle completion pulse to the fetcher.

## Operation
Decode fields: cc = op[1:0], bbb = op[4:2], aaa = op[7:5]. Each instruction falls into exactly one class.
- STORE: aaa=100, and not (bbb=010), and not (cc≠01 and bbb=110).
  - Source register by cc: 01 selects A, 10 selects X, 00 selects Y.
- RMW: cc=10, aaa≠100/101, bbb∈{001,011,101,111}.
- IMM: (cc=01, bbb=010), or (cc∈{00,10}, bbb=000, aaa≥101).
- READ: remaining cc=01; cc=10 with aaa=101 and bbb∈{001,011,101,111}; cc=00 with aaa∈{001,101,110,111} and bbb∈{001,011,101,111}.
- IMPLIED: everything else. No bus cycle; operand=0.

Start condition:
- Start only on a rising edge of `instruction_ready` (detected against `ready_d`) while in IDLE.
- `ready_d` resets to 1, because the fetcher drives ready high during reset; no spurious start follows reset.
- On start, latch opcode, `addr_in` and `imm_in`. Rises seen while `busy` are ignored and not queued.

State machine (one state per `phi1` cycle):
- IDLE → OPERAND (IMM/IMPLIED), READ (READ/RMW), or WRITE (STORE).
- READ: `mem_rd`=1, `mem_addr`=latched address; `mem_rdata` is sampled into `operand` at the cycle's end → CAPTURE.
- CAPTURE: `operand_valid`=1 → DONE (READ) or MODIFY (RMW).
- OPERAND: `operand`=imm (or 0), `operand_valid`=1 → DONE.
- MODIFY: `alu_result` is latched into the write-data register → WRITE.
- WRITE: `mem_wr`=1, `mem_addr`=latched address.
  - `mem_wdata` is the selected register for STORE, or the modified value for RMW → DONE.
- DONE: `instruction_done`=1 → IDLE.

Width rules: addresses pass through unmodified; no arithmetic is done here.

## Timing
- Cycle 0 is the first `phi1` edge at which the ready rise is seen.
- Done pulse cycle by class: IMM/IMPLIED 2, STORE 2, READ 3, RMW 5 (6 with dummy write).
- All outputs are registered. Reset values: every output 0 and state IDLE.
- Reset asserted mid-operation: outputs clear immediately and asynchronously, including `mem_wr`; no done pulse.
  - After release, a fresh ready rise is required.
- Between bus states, `mem_addr` holds its last value; strobes are low.

## Configuration
- `NES_RMW_DUMMY_WRITE_EN` defined: RMW inserts state WRITE_DUMMY between CAPTURE and MODIFY.
  - WRITE_DUMMY writes the unmodified operand to the same address, matching 6502 bus behaviour.
  - RMW done pulse moves to cycle 6.
- Undefined: no dummy write; RMW done at cycle 5.

## Structure
- Shared defines header holds:
  - class codes `CLASS_IMPLIED/IMM/READ/STORE/RMW`;
  - state encodings `EXS_*`;
  - `REG_WIDTH`/`ADDR_WIDTH`.
- Sub-module `opcode_classifier`: combinational, opcode → class plus 2-bit store-source select.

## Test plan
- LDA #$42 (A9, imm 42): `operand`=42 with `operand_valid` at cycle 1, done at cycle 2; `mem_rd`/`mem_wr` never assert.
- LDA $1234 (AD), `mem_rdata`=5A: `mem_rd` high cycle 1 at 1234; operand 5A valid at cycle 2; done at cycle 3.
- STX $0010 (86), X=77: `mem_wr` at cycle 1, addr 0010, data 77; done at cycle 2; no read.
- INC $0200 (EE), memory 7F, `alu_result` 80: read 0200, write 80 at cycle 4, done at cycle 5.
  - With the macro defined: extra write of 7F at cycle 3, write of 80 at cycle 5, done at cycle 6.
- Reset pulled during the RMW WRITE: `mem_wr` drops without waiting for `phi1`; no done.
  - Ready held high across reset release: no start until ready goes low then high.
- Ready toggled low/high during a READ sequence: ignored, exactly one done pulse, and IDLE is reached afterwards.

Source files
------------

// File: rtl/exec_sequencer_pkg.sv
// rtl/exec_sequencer_pkg.sv - shared widths, class codes and state encodings for exec_sequencer
package exec_sequencer_pkg;

  localparam int REG_WIDTH  = 8;
  localparam int ADDR_WIDTH = 16;

  typedef enum logic [2:0] {
    CLASS_IMPLIED = 3'd0,
    CLASS_IMM     = 3'd1,
    CLASS_READ    = 3'd2,
    CLASS_STORE   = 3'd3,
    CLASS_RMW     = 3'd4
  } class_e;

  typedef enum logic [1:0] {
    SRC_A = 2'd0,
    SRC_X = 2'd1,
    SRC_Y = 2'd2
  } src_e;

  typedef enum logic [2:0] {
    EXS_IDLE        = 3'd0,
    EXS_OPERAND     = 3'd1,
    EXS_READ        = 3'd2,
    EXS_CAPTURE     = 3'd3,
    EXS_MODIFY      = 3'd4,
    EXS_WRITE       = 3'd5,
    EXS_WRITE_DUMMY = 3'd6,
    EXS_DONE        = 3'd7
  } state_e;

  // States whose registered outputs put the latched address on the bus.
  function automatic logic drives_bus(input state_e s);
    return (s == EXS_READ) || (s == EXS_WRITE) || (s == EXS_WRITE_DUMMY);
  endfunction

endpackage

// File: rtl/exec_sequencer_if.sv
// rtl/exec_sequencer_if.sv - data-bus interface between exec_sequencer (master) and memory (slave)
interface exec_sequencer_if #(
  parameter int REG_WIDTH  = exec_sequencer_pkg::REG_WIDTH,
  parameter int ADDR_WIDTH = exec_sequencer_pkg::ADDR_WIDTH
);

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rd;
  logic                  mem_wr;
  logic [REG_WIDTH-1:0]  mem_wdata;
  logic [REG_WIDTH-1:0]  mem_rdata;

  modport master (
    output mem_addr,
    output mem_rd,
    output mem_wr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_rd,
    input  mem_wr,
    input  mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/exec_sequencer_opcode_classifier.sv
// rtl/exec_sequencer_opcode_classifier.sv - combinational opcode to execution class and store source
module opcode_classifier
  import exec_sequencer_pkg::*;
(
  input  logic [7:0] opcode,
  output class_e     op_class,
  output src_e       store_src
);

  logic [1:0] cc;
  logic [2:0] bbb;
  logic [2:0] aaa;
  logic       indexed_mode;
  logic       is_store;
  logic       is_rmw;
  logic       is_imm;
  logic       is_read;

  assign cc  = opcode[1:0];
  assign bbb = opcode[4:2];
  assign aaa = opcode[7:5];

  // bbb in {001,011,101,111}: the memory addressing modes of the cc=00/10 groups
  assign indexed_mode = bbb[0];

  always_comb begin
    is_store = (aaa == 3'b100) && (bbb != 3'b010) &&
               !((cc != 2'b01) && (bbb == 3'b110));
    is_rmw   = (cc == 2'b10) && (aaa != 3'b100) && (aaa != 3'b101) && indexed_mode;
    is_imm   = ((cc == 2'b01) && (bbb == 3'b010)) ||
               (((cc == 2'b00) || (cc == 2'b10)) && (bbb == 3'b000) && (aaa >= 3'b101));
    is_read  = (cc == 2'b01) ||
               ((cc == 2'b10) && (aaa == 3'b101) && indexed_mode) ||
               ((cc == 2'b00) && indexed_mode &&
                ((aaa == 3'b001) || (aaa >= 3'b101)));

    if (is_store)     op_class = CLASS_STORE;
    else if (is_rmw)  op_class = CLASS_RMW;
    else if (is_imm)  op_class = CLASS_IMM;
    else if (is_read) op_class = CLASS_READ;
    else              op_class = CLASS_IMPLIED;

    case (cc)
      2'b10:   store_src = SRC_X;
      2'b00:   store_src = SRC_Y;
      default: store_src = SRC_A;
    endcase
  end

endmodule

// File: rtl/exec_sequencer.sv
// rtl/exec_sequencer.sv - instruction execution sequencer; NES_RMW_DUMMY_WRITE_EN adds the 6502 RMW dummy write
module exec_sequencer #(
  parameter int REG_WIDTH  = exec_sequencer_pkg::REG_WIDTH,
  parameter int ADDR_WIDTH = exec_sequencer_pkg::ADDR_WIDTH
) (
  input  logic                  phi1,
  input  logic                  reset_n,
  input  logic                  instruction_ready,
  input  logic [REG_WIDTH-1:0]  instruction_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [REG_WIDTH-1:0]  imm_in,
  input  logic [REG_WIDTH-1:0]  reg_a,
  input  logic [REG_WIDTH-1:0]  reg_x,
  input  logic [REG_WIDTH-1:0]  reg_y,
  input  logic [REG_WIDTH-1:0]  alu_result,
  exec_sequencer_if.master      mem,
  output logic [REG_WIDTH-1:0]  operand,
  output logic                  operand_valid,
  output logic                  busy,
  output logic                  instruction_done
);

  import exec_sequencer_pkg::*;

  state_e                state_q;
  state_e                state_d;
  logic                  ready_d;
  logic                  start;
  logic [REG_WIDTH-1:0]  opcode_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [REG_WIDTH-1:0]  imm_q;
  logic [REG_WIDTH-1:0]  op_sel;
  class_e                op_class;
  src_e                  store_src;
  logic                  rd_d;
  logic                  wr_d;
  logic                  ov_d;
  logic                  done_d;
  logic [REG_WIDTH-1:0]  src_val;

  assign start = (state_q == EXS_IDLE) && instruction_ready && !ready_d;

  // In IDLE the incoming opcode steers the first transition; afterwards the latched one.
  assign op_sel = (state_q == EXS_IDLE) ? instruction_in : opcode_q;

  opcode_classifier u_classifier (
    .opcode    (op_sel[7:0]),
    .op_class  (op_class),
    .store_src (store_src)
  );

  always_ff @(posedge phi1 or negedge reset_n) begin
    if (!reset_n) state_q <= EXS_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EXS_IDLE: begin
        if (start) begin
          case (op_class)
            CLASS_READ, CLASS_RMW: state_d = EXS_READ;
            CLASS_STORE:           state_d = EXS_WRITE;
            default:               state_d = EXS_OPERAND;
          endcase
        end
      end
      EXS_READ:    state_d = EXS_CAPTURE;
      EXS_CAPTURE: begin
        if (op_class == CLASS_RMW) begin
`ifdef NES_RMW_DUMMY_WRITE_EN
          state_d = EXS_WRITE_DUMMY;
`else
          state_d = EXS_MODIFY;
`endif
        end else begin
          state_d = EXS_DONE;
        end
      end
      EXS_WRITE_DUMMY: state_d = EXS_MODIFY;
      EXS_MODIFY:      state_d = EXS_WRITE;
      EXS_WRITE:       state_d = EXS_DONE;
      EXS_OPERAND:     state_d = EXS_DONE;
      EXS_DONE:        state_d = EXS_IDLE;
      default:         state_d = EXS_IDLE;
    endcase

    // Outputs are registered from the current state, so each appears one cycle after entry.
    rd_d   = (state_q == EXS_READ);
    wr_d   = (state_q == EXS_WRITE) || (state_q == EXS_WRITE_DUMMY);
    ov_d   = (state_q == EXS_CAPTURE) || (state_q == EXS_OPERAND);
    done_d = (state_q == EXS_DONE);

    case (store_src)
      SRC_X:   src_val = reg_x;
      SRC_Y:   src_val = reg_y;
      default: src_val = reg_a;
    endcase
  end

  always_ff @(posedge phi1 or negedge reset_n) begin
    if (!reset_n) begin
      ready_d          <= 1'b1;
      opcode_q         <= '0;
      addr_q           <= '0;
      imm_q            <= '0;
      mem.mem_addr     <= '0;
      mem.mem_rd       <= 1'b0;
      mem.mem_wr       <= 1'b0;
      mem.mem_wdata    <= '0;
      operand          <= '0;
      operand_valid    <= 1'b0;
      busy             <= 1'b0;
      instruction_done <= 1'b0;
    end else begin
      ready_d          <= instruction_ready;
      mem.mem_rd       <= rd_d;
      mem.mem_wr       <= wr_d;
      operand_valid    <= ov_d;
      instruction_done <= done_d;
      busy             <= (state_d != EXS_IDLE);

      if (start) begin
        opcode_q <= instruction_in;
        addr_q   <= addr_in;
        imm_q    <= imm_in;
      end

      if (drives_bus(state_q)) mem.mem_addr <= addr_q;

      // Read data is taken at the end of the cycle in which mem_rd is presented.
      if (state_q == EXS_OPERAND)
        operand <= (op_class == CLASS_IMM) ? imm_q : '0;
      else if (mem.mem_rd)
        operand <= mem.mem_rdata;

      case (state_q)
        EXS_WRITE_DUMMY: mem.mem_wdata <= operand;
        EXS_MODIFY:      mem.mem_wdata <= alu_result;
        EXS_WRITE:       if (op_class == CLASS_STORE) mem.mem_wdata <= src_val;
        default:         ;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// tb/tb_exec_sequencer.sv - self-checking bench for exec_sequencer; honours NES_RMW_DUMMY_WRITE_EN
`timescale 1ns/1ps
module tb_exec_sequencer;

  localparam int RW   = 8;
  localparam int AW   = 16;
  localparam int NCYC = 9;
`ifdef NES_RMW_DUMMY_WRITE_EN
  localparam bit DUMMY = 1'b1;
`else
  localparam bit DUMMY = 1'b0;
`endif
  localparam int C_IMPLIED = 0, C_IMM = 1, C_READ = 2, C_STORE = 3, C_RMW = 4;

  logic          phi1 = 1'b0;
  logic          reset_n = 1'b0;
  logic          instruction_ready = 1'b1;
  logic [RW-1:0] instruction_in = '0, imm_in = '0, reg_a = '0, reg_x = '0, reg_y = '0;
  logic [RW-1:0] alu_k = '0, rdata_v = '0;
  logic [AW-1:0] addr_in = '0;
  logic [RW-1:0] alu_result, operand;
  logic          operand_valid, busy, instruction_done;

  int ncmp = 0;
  int nerr = 0;

  exec_sequencer_if #(.REG_WIDTH(RW), .ADDR_WIDTH(AW)) mem ();

  assign mem.mem_rdata = rdata_v;
  assign alu_result    = operand + alu_k;

  exec_sequencer #(.REG_WIDTH(RW), .ADDR_WIDTH(AW)) dut (
    .phi1              (phi1),
    .reset_n           (reset_n),
    .instruction_ready (instruction_ready),
    .instruction_in    (instruction_in),
    .addr_in           (addr_in),
    .imm_in            (imm_in),
    .reg_a             (reg_a),
    .reg_x             (reg_x),
    .reg_y             (reg_y),
    .alu_result        (alu_result),
    .mem               (mem),
    .operand           (operand),
    .operand_valid     (operand_valid),
    .busy              (busy),
    .instruction_done  (instruction_done)
  );

  always #5 phi1 = ~phi1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int ref_class(input logic [7:0] op);
    int cc;
    int bbb;
    int aaa;
    bit mem_mode;
    cc  = int'(op[1:0]);
    bbb = int'(op[4:2]);
    aaa = int'(op[7:5]);
    mem_mode = bbb inside {1, 3, 5, 7};
    if (aaa == 4 && bbb != 2 && !(cc != 1 && bbb == 6)) return C_STORE;
    if (cc == 2 && !(aaa inside {4, 5}) && mem_mode) return C_RMW;
    if ((cc == 1 && bbb == 2) || (cc inside {0, 2} && bbb == 0 && aaa >= 5)) return C_IMM;
    if (cc == 1 || (cc == 2 && aaa == 5 && mem_mode) ||
        (cc == 0 && aaa inside {1, 5, 6, 7} && mem_mode)) return C_READ;
    return C_IMPLIED;
  endfunction

  // Expected per-cycle activity, cycle 0 being the edge that sees the ready rise.
  bit [NCYC-1:0] e_rd, e_wr, e_ov, e_dn, e_bz;
  logic [7:0]    e_opv [NCYC];
  logic [7:0]    e_wdv [NCYC];

  task automatic build_expect(input logic [7:0] op, input logic [7:0] im, input logic [7:0] rd,
                              input logic [7:0] a, input logic [7:0] x, input logic [7:0] y,
                              input logic [7:0] k);
    int len;
    e_rd = '0; e_wr = '0; e_ov = '0; e_dn = '0; e_bz = '0;
    for (int c = 0; c < NCYC; c++) begin
      e_opv[c] = '0;
      e_wdv[c] = '0;
    end
    case (ref_class(op))
      C_IMM, C_IMPLIED: begin
        len = 2; e_ov[1] = 1'b1;
        e_opv[1] = (ref_class(op) == C_IMM) ? im : 8'h00;
      end
      C_STORE: begin
        len = 2; e_wr[1] = 1'b1;
        e_wdv[1] = (op[1:0] == 2'b10) ? x : (op[1:0] == 2'b00) ? y : a;
      end
      C_READ: begin
        len = 3; e_rd[1] = 1'b1; e_ov[2] = 1'b1; e_opv[2] = rd;
      end
      default: begin
        e_rd[1] = 1'b1; e_ov[2] = 1'b1; e_opv[2] = rd;
        if (DUMMY) begin
          len = 6; e_wr[3] = 1'b1; e_wdv[3] = rd; e_wr[5] = 1'b1; e_wdv[5] = rd + k;
        end else begin
          len = 5; e_wr[4] = 1'b1; e_wdv[4] = rd + k;
        end
      end
    endcase
    e_dn[len] = 1'b1;
    for (int c = 0; c < len; c++) e_bz[c] = 1'b1;
  endtask

  task automatic run_instr(input logic [7:0] op, input logic [15:0] ad, input logic [7:0] im,
                           input logic [7:0] rd, input logic [7:0] a, input logic [7:0] x,
                           input logic [7:0] y, input logic [7:0] k,
                           output int done_cyc, output logic [7:0] last_val);
    build_expect(op, im, rd, a, x, y, k);
    @(negedge phi1);
    instruction_in = op; addr_in = ad; imm_in = im; rdata_v = rd;
    reg_a = a; reg_x = x; reg_y = y; alu_k = k;
    instruction_ready = 1'b1;
    done_cyc = -1;
    last_val = '0;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge phi1); #1;
      check($sformatf("flags op=%02h cyc=%0d {rd,wr,ov,done,busy}", op, c),
            {27'd0, mem.mem_rd, mem.mem_wr, operand_valid, instruction_done, busy},
            {27'd0, e_rd[c], e_wr[c], e_ov[c], e_dn[c], e_bz[c]});
      if (e_rd[c] || e_wr[c]) check($sformatf("addr op=%02h cyc=%0d", op, c), 32'(mem.mem_addr), 32'(ad));
      if (e_wr[c]) check($sformatf("wdata op=%02h cyc=%0d", op, c), 32'(mem.mem_wdata), 32'(e_wdv[c]));
      if (e_ov[c]) check($sformatf("operand op=%02h cyc=%0d", op, c), 32'(operand), 32'(e_opv[c]));
      if (instruction_done && done_cyc < 0) done_cyc = c;
      if (operand_valid) last_val = operand;
      if (mem.mem_wr) last_val = mem.mem_wdata;
    end
    @(negedge phi1);
    instruction_ready = 1'b0;
    @(posedge phi1);
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [15:0] ad;
    logic [7:0]  im, rd, a, x, y, k;
    int          exp_done;
    logic [7:0]  exp_val;
  } vec_t;

  vec_t       tbl [9];
  int         dc;
  logic [7:0] lv;
  logic [7:0] rop;
  int         dones;
  int         first_done;
  logic       seen;

  initial begin
    tbl[0] = '{8'hA9, 16'h0000, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2, 8'h42};
    tbl[1] = '{8'hAD, 16'h1234, 8'h00, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 3, 8'h5A};
    tbl[2] = '{8'h86, 16'h0010, 8'h00, 8'h00, 8'h11, 8'h77, 8'h22, 8'h00, 2, 8'h77};
    tbl[3] = '{8'hEE, 16'h0200, 8'h00, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h01, DUMMY ? 6 : 5, 8'h80};
    tbl[4] = '{8'hEA, 16'h0000, 8'h99, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2, 8'h00};
    tbl[5] = '{8'h8D, 16'h3456, 8'h00, 8'h00, 8'hC3, 8'h44, 8'h55, 8'h00, 2, 8'hC3};
    tbl[6] = '{8'hA2, 16'h0000, 8'h5E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2, 8'h5E};
    tbl[7] = '{8'h8C, 16'h0044, 8'h00, 8'h00, 8'h66, 8'h77, 8'hD1, 8'h00, 2, 8'hD1};
    tbl[8] = '{8'h2C, 16'h00FF, 8'h00, 8'h81, 8'h00, 8'h00, 8'h00, 8'h00, 3, 8'h81};

    // Reset with ready held high, as the fetcher does.
    repeat (3) @(posedge phi1);
    #1;
    check("reset flags {rd,wr,ov,done,busy}",
          {27'd0, mem.mem_rd, mem.mem_wr, operand_valid, instruction_done, busy}, 32'd0);
    check("reset mem_addr", 32'(mem.mem_addr), 32'd0);
    check("reset operand/wdata", {16'd0, operand, mem.mem_wdata}, 32'd0);
    @(negedge phi1);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(posedge phi1); #1;
      seen = seen | busy | mem.mem_rd | mem.mem_wr | instruction_done;
    end
    check("no start with ready high out of reset", 32'(seen), 32'd0);
    @(negedge phi1);
    instruction_ready = 1'b0;
    @(posedge phi1);

    for (int i = 0; i < 9; i++) begin
      run_instr(tbl[i].op, tbl[i].ad, tbl[i].im, tbl[i].rd, tbl[i].a, tbl[i].x,
                tbl[i].y, tbl[i].k, dc, lv);
      check($sformatf("table[%0d] done cycle", i), 32'(dc), 32'(tbl[i].exp_done));
      check($sformatf("table[%0d] result", i), 32'(lv), 32'(tbl[i].exp_val));
    end

    // Reset pulled while the RMW final write is on the bus.
    @(negedge phi1);
    instruction_in = 8'hEE; addr_in = 16'h0200; rdata_v = 8'h7F; alu_k = 8'h01;
    instruction_ready = 1'b1;
    @(posedge phi1);
    repeat (DUMMY ? 5 : 4) @(posedge phi1);
    #1;
    check("rmw write active before reset", 32'(mem.mem_wr), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async reset clears {rd,wr,ov,done,busy}",
          {27'd0, mem.mem_rd, mem.mem_wr, operand_valid, instruction_done, busy}, 32'd0);
    @(posedge phi1);
    @(negedge phi1);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge phi1); #1;
      seen = seen | busy | mem.mem_rd | mem.mem_wr | instruction_done;
    end
    check("no done/start after mid-op reset", 32'(seen), 32'd0);
    @(negedge phi1);
    instruction_ready = 1'b0;
    @(posedge phi1);
    run_instr(8'hA9, 16'h0000, 8'h3E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, dc, lv);
    check("restart after reset done cycle", 32'(dc), 32'd2);

    // Ready toggled during a READ sequence is ignored.
    @(negedge phi1);
    instruction_in = 8'hAD; addr_in = 16'h4321; rdata_v = 8'h3C;
    instruction_ready = 1'b1;
    dones = 0;
    first_done = -1;
    for (int c = 0; c < 10; c++) begin
      @(posedge phi1); #1;
      if (instruction_done) begin
        dones++;
        if (first_done < 0) first_done = c;
      end
      if (c == 0) begin @(negedge phi1); instruction_ready = 1'b0; end
      if (c == 1) begin @(negedge phi1); instruction_ready = 1'b1; end
    end
    check("toggle: done pulses", 32'(dones), 32'd1);
    check("toggle: done cycle", 32'(first_done), 32'd3);
    check("toggle: idle afterwards", 32'(busy), 32'd0);
    @(negedge phi1);
    instruction_ready = 1'b0;
    @(posedge phi1);

    for (int i = 0; i < 40; i++) begin
      rop = 8'($urandom);
      if (rop[1:0] == 2'b11) rop[1:0] = 2'($urandom_range(0, 2));
      run_instr(rop, 16'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                8'($urandom), 8'($urandom), 8'($urandom), dc, lv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
